// File: rtl/spi_arbiter.sv
// Two-port round-robin arbiter in front of a single SPI flash master.
// One transfer outstanding at a time; a granted transfer ends on spi_valid
// or is aborted after TIMEOUT_CYCLES cycles. The ack strobe, err and rdata
// are registered.
module spi_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic [23:0] p0_addr,
   input  logic [1:0]  p0_byte_mask,
   output logic        p0_ack,
   input  logic        p1_req,
   input  logic        p1_write,
   input  logic [23:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [1:0]  p1_byte_mask,
   output logic        p1_ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        spi_req,
   output logic        spi_write,
   output logic [23:0] spi_addr,
   output logic [31:0] spi_data_in,
   output logic [1:0]  spi_byte_mask,
   input  logic [31:0] spi_data_out,
   input  logic        spi_valid
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;   // port granted most recently
   logic          gnt_q, gnt_d;     // port owning the current transfer
   logic          spi_req_q, spi_req_d;
   logic          p0_ack_q, p0_ack_d;
   logic          p1_ack_q, p1_ack_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          spi_write_q, spi_write_d;
   logic [23:0]   spi_addr_q, spi_addr_d;
   logic [31:0]   spi_data_in_q, spi_data_in_d;
   logic [1:0]    spi_byte_mask_q, spi_byte_mask_d;
   logic          pick;
   logic [31:0]   masked;

   // Read data trimmed to the transfer size; writes return zero
   always_comb begin
      masked = '0;
      if (!spi_write_q) begin
         case (spi_byte_mask_q)
            2'b00:   masked = {spi_data_out[31:24], 24'h0};
            2'b01:   masked = {spi_data_out[31:16], 16'h0};
            default: masked = spi_data_out;
         endcase
      end
   end

   // Round-robin choice: on a tie take the port not granted last
   always_comb begin
      pick = (p0_req && p1_req) ? ~last_q : ~p0_req;
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      last_d          = last_q;
      gnt_d           = gnt_q;
      spi_req_d       = spi_req_q;
      spi_write_d     = spi_write_q;
      spi_addr_d      = spi_addr_q;
      spi_data_in_d   = spi_data_in_q;
      spi_byte_mask_d = spi_byte_mask_q;
      p0_ack_d        = 1'b0;
      p1_ack_d        = 1'b0;
      err_d           = 1'b0;
      rdata_d         = '0;
      case (state_q)
         IDLE: begin
            spi_req_d = 1'b1;
            if (p0_req || p1_req) begin
               state_d   = RUN;
               gnt_d     = pick;
               last_d    = pick;
               spi_req_d = 1'b0;
               cnt_d     = '0;
               if (pick) begin
                  spi_write_d     = p1_write;
                  spi_addr_d      = p1_addr;
                  spi_data_in_d   = p1_wdata;
                  spi_byte_mask_d = p1_byte_mask;
               end else begin
                  spi_write_d     = 1'b0;
                  spi_addr_d      = p0_addr;
                  spi_data_in_d   = '0;
                  spi_byte_mask_d = p0_byte_mask;
               end
            end
         end
         RUN: begin
            spi_req_d = 1'b0;
            // spi_valid takes priority over a coincident timeout
            if (spi_valid || (cnt_q == CNT_LAST)) begin
               p0_ack_d  = ~gnt_q;
               p1_ack_d  = gnt_q;
               err_d     = ~spi_valid;
               rdata_d   = spi_valid ? masked : '0;
               spi_req_d = 1'b1;
               state_d   = RECOVER;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RECOVER: begin
            spi_req_d = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d   = IDLE;
            spi_req_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         last_q          <= 1'b1;
         gnt_q           <= 1'b0;
         spi_req_q       <= 1'b1;
         p0_ack_q        <= 1'b0;
         p1_ack_q        <= 1'b0;
         err_q           <= 1'b0;
         rdata_q         <= '0;
         spi_write_q     <= 1'b0;
         spi_addr_q      <= '0;
         spi_data_in_q   <= '0;
         spi_byte_mask_q <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         last_q          <= last_d;
         gnt_q           <= gnt_d;
         spi_req_q       <= spi_req_d;
         p0_ack_q        <= p0_ack_d;
         p1_ack_q        <= p1_ack_d;
         err_q           <= err_d;
         rdata_q         <= rdata_d;
         spi_write_q     <= spi_write_d;
         spi_addr_q      <= spi_addr_d;
         spi_data_in_q   <= spi_data_in_d;
         spi_byte_mask_q <= spi_byte_mask_d;
      end
   end

   assign p0_ack        = p0_ack_q;
   assign p1_ack        = p1_ack_q;
   assign err           = err_q;
   assign rdata         = rdata_q;
   assign spi_req       = spi_req_q;
   assign spi_write     = spi_write_q;
   assign spi_addr      = spi_addr_q;
   assign spi_data_in   = spi_data_in_q;
   assign spi_byte_mask = spi_byte_mask_q;

endmodule
